view_project: RTL and testbench

Inverse of the ray-generation stage: takes a world-space point (10-10-8 x-y-z packed, same format as ray directions) and the current view (normal, distance) and projects it back onto the 128×64 screen, returning the packed pixel location used by the ray generator (y 6 bits at [12:7], x 7 bits at [6:0]). It sits between the intersection/shading path and the framebuffer/pick logic. It is multi-cycle, with a valid/ready handshake on both sides and one shared iterative divider.

---
 rtl/vtracer_pkg.sv | 37 +++
 rtl/view_project_if.sv | 26 ++
 rtl/view_div.sv | 65 ++++++
 rtl/view_project.sv | 170 +++++++++++++++++
 tb/tb_view_project.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/vtracer_pkg.sv
// Shared widths, screen geometry, packed-vector field positions and FSM states
// for the view projection path.
package vtracer_pkg;

  localparam int unsigned XW   = 10;             // x/y field width of a packed vector
  localparam int unsigned ZW   = 8;              // z field width
  localparam int unsigned DW   = 10;             // screen distance width
  localparam int unsigned VECW = 2 * XW + ZW;
  localparam int unsigned LOCX = 7;
  localparam int unsigned LOCY = 6;
  localparam int unsigned LOCW = LOCX + LOCY;
  localparam int unsigned DEPW = 21;             // dot-product width
  localparam int unsigned NW   = 31;             // scaled numerator width
  localparam int unsigned QW   = 7;              // quotient width
  localparam int unsigned SW   = 9;              // signed screen coordinate width

  localparam int unsigned CX = 64;
  localparam int unsigned CY = 32;

  localparam int unsigned VX_LSB = XW + ZW;
  localparam int unsigned VY_LSB = ZW;
  localparam int unsigned VZ_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DOT,
    ST_SCALE,
    ST_DIVX,
    ST_DIVY,
    ST_DONE
  } state_e;

  function automatic logic [DEPW-1:0] mag(input logic signed [DEPW-1:0] v);
    return v[DEPW-1] ? DEPW'(-v) : DEPW'(v);
  endfunction

endpackage

// File: rtl/view_project_if.sv
// Request/response bundle between the shading path and the view projector.
interface view_project_if;
  import vtracer_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [VECW-1:0] view_normal;
  logic [DW-1:0]   view_dist;
  logic [VECW-1:0] point;
  logic            out_valid;
  logic            out_ready;
  logic [LOCW-1:0] view_loc;
  logic            off_screen;
  logic            behind;

  modport master (
    output in_valid, view_normal, view_dist, point, out_ready,
    input  in_ready, out_valid, view_loc, off_screen, behind
  );

  modport slave (
    input  in_valid, view_normal, view_dist, point, out_ready,
    output in_ready, out_valid, view_loc, off_screen, behind
  );

endinterface

// File: rtl/view_div.sv
// Fixed 8-cycle restoring divider: one saturation-check cycle on start, then
// seven MSB-first iterations that always run so the latency never varies.
module view_div
  import vtracer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [NW-1:0]   num_i,
  input  logic [DEPW-1:0] den_i,
  output logic [QW-1:0]   q_o,
  output logic            sat_o,
  output logic            busy_o,
  output logic            last_o
);

  logic [NW-1:0]   rem_q;
  logic [DEPW-1:0] den_q;
  logic [QW-1:0]   quo_q;
  logic [2:0]      step_q;
  logic            sat_q, busy_q, last_q;
  logic [NW:0]     trial_c;
  logic            fits_c, sat_c;

  always_comb begin
    trial_c = (NW+1)'(den_q) << step_q;
    fits_c  = (NW+1)'(rem_q) >= trial_c;
    sat_c   = (NW+1)'(num_i) >= ((NW+1)'(den_i) << QW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      step_q <= '0;
      sat_q  <= 1'b0;
      busy_q <= 1'b0;
      last_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= num_i;
      den_q  <= den_i;
      quo_q  <= sat_c ? '1 : '0;
      step_q <= 3'(QW - 1);
      sat_q  <= sat_c;
      busy_q <= 1'b1;
      last_q <= 1'b0;
    end else if (busy_q) begin
      // a saturated result keeps its all-ones quotient while the steps run out
      if (fits_c && !sat_q) begin
        rem_q         <= rem_q - NW'(trial_c);
        quo_q[step_q] <= 1'b1;
      end
      step_q <= step_q - 3'd1;
      last_q <= (step_q == 3'd1);
      busy_q <= !last_q;
    end
  end

  assign q_o    = quo_q;
  assign sat_o  = sat_q;
  assign busy_o = busy_q;
  assign last_o = last_q;

endmodule

// File: rtl/view_project.sv
// Projects a world-space point back onto the 128x64 screen for the current view.
// VIEW_PROJECT_CLAMP_EN: clamp off-screen coordinates to the edge instead of zeroing view_loc.
module view_project
  import vtracer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  view_project_if.slave bus
);

  state_e state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [LOCW-1:0] loc_q, loc_d;
  logic            off_q, off_d;
  logic            behind_q, behind_d;

  logic [VECW-1:0]        pt_q;
  logic [XW-1:0]          dirx_q, diry_q;
  logic [DW-1:0]          dist_q;
  logic signed [DEPW-1:0] depth_q, lat_q;
  logic signed [ZW-1:0]   vert_q;
  logic                   beh_q;
  logic [NW-1:0]          nx_q, ny_q;
  logic [QW-1:0]          qx_q;
  logic                   satx_q;

  logic                   accept_c, div_start_c, dot_behind_c;
  logic [NW-1:0]          div_num_c;
  logic signed [XW-1:0]   px_c, py_c, dx_c, dy_c;
  logic signed [DEPW-1:0] dot_depth_c, dot_lat_c;
  logic [SW-1:0]          x_c, y_c;
  logic                   map_off_c;
  logic [LOCW-1:0]        map_loc_c;
  logic [QW-1:0]          div_q;
  logic                   div_sat, div_busy, div_last;
  logic                   unused_dz;

  assign unused_dz = ^bus.view_normal[VZ_LSB +: ZW];

  view_div u_div (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_start_c),
    .num_i   (div_num_c),
    .den_i   (depth_q),
    .q_o     (div_q),
    .sat_o   (div_sat),
    .busy_o  (div_busy),
    .last_o  (div_last)
  );

  // Lateral offset is positive toward screen left.
  always_comb begin
    px_c         = pt_q[VX_LSB +: XW];
    py_c         = pt_q[VY_LSB +: XW];
    dx_c         = dirx_q;
    dy_c         = diry_q;
    dot_depth_c  = DEPW'(px_c) * DEPW'(dx_c) + DEPW'(py_c) * DEPW'(dy_c);
    dot_lat_c    = DEPW'(py_c) * DEPW'(dx_c) - DEPW'(px_c) * DEPW'(dy_c);
    dot_behind_c = dot_depth_c[DEPW-1] || (dot_depth_c == '0);
  end

  // Screen mapping from the two quotients; qy is read straight off the divider.
  always_comb begin
    x_c       = lat_q[DEPW-1]  ? SW'(CX) + SW'(qx_q)  : SW'(CX) - SW'(qx_q);
    y_c       = vert_q[ZW-1]   ? SW'(CY) - SW'(div_q) : SW'(CY) + SW'(div_q);
    map_off_c = (|x_c[SW-1:LOCX]) || (|y_c[SW-1:LOCY]) || satx_q || div_sat;
`ifdef VIEW_PROJECT_CLAMP_EN
    map_loc_c[LOCX-1:0]    = !(|x_c[SW-1:LOCX]) ? x_c[LOCX-1:0] : (x_c[SW-1] ? '0 : '1);
    map_loc_c[LOCW-1:LOCX] = !(|y_c[SW-1:LOCY]) ? y_c[LOCY-1:0] : (y_c[SW-1] ? '0 : '1);
`else
    map_loc_c = map_off_c ? '0 : {y_c[LOCY-1:0], x_c[LOCX-1:0]};
`endif
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    loc_d       = loc_q;
    off_d       = off_q;
    behind_d    = behind_q;
    accept_c    = 1'b0;
    div_start_c = 1'b0;
    div_num_c   = nx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          accept_c   = 1'b1;
          in_ready_d = 1'b0;
          state_d    = ST_DOT;
        end
      end
      ST_DOT:   state_d = dot_behind_c ? ST_DONE : ST_SCALE;
      ST_SCALE: state_d = ST_DIVX;
      ST_DIVX: begin
        div_start_c = !div_busy;
        if (div_last) state_d = ST_DIVY;
      end
      ST_DIVY: begin
        div_num_c   = ny_q;
        div_start_c = !div_busy;
        if (div_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        // first DONE cycle latches the mapped result, then hold until taken
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          loc_d       = beh_q ? '0 : map_loc_c;
          off_d       = beh_q ? 1'b0 : map_off_c;
          behind_d    = beh_q;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      loc_q       <= '0;
      off_q       <= 1'b0;
      behind_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      loc_q       <= loc_d;
      off_q       <= off_d;
      behind_q    <= behind_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_c) begin
      pt_q   <= bus.point;
      dirx_q <= bus.view_normal[VX_LSB +: XW];
      diry_q <= bus.view_normal[VY_LSB +: XW];
      dist_q <= bus.view_dist;
    end
    if (state_q == ST_DOT) begin
      depth_q <= dot_depth_c;
      lat_q   <= dot_lat_c;
      vert_q  <= pt_q[VZ_LSB +: ZW];
      beh_q   <= dot_behind_c;
    end
    if (state_q == ST_SCALE) begin
      nx_q <= NW'(mag(lat_q)) * NW'(dist_q);
      ny_q <= NW'(mag(DEPW'(vert_q))) * NW'(dist_q);
    end
    if (state_q == ST_DIVY && div_start_c) begin
      qx_q   <= div_q;
      satx_q <= div_sat;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.view_loc   = loc_q;
  assign bus.off_screen = off_q;
  assign bus.behind     = behind_q;

endmodule

// File: tb/tb_view_project.sv
// Scoreboard bench for view_project: driver queues expected results, monitor
// compares them when out_valid rises and while the result is held under stall.
module tb_view_project;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  view_project_if bus ();

  view_project dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef VIEW_PROJECT_CLAMP_EN
  localparam bit CL = 1'b1;
`else
  localparam bit CL = 1'b0;
`endif

  typedef struct {
    logic [12:0] loc;
    logic        off;
    logic        beh;
    int          lat;
    int          stall;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   retire_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic send(input int dx, input int dy, input int px, input int py, input int pz,
                      input int d0, input int loc, input bit off, input bit beh,
                      input int stall, input bit b2b);
    exp_t e;
    int   waitc;
    waitc = 0;
    @(negedge clk);
    while (!bus.in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready still %0d after %0d cycles", bus.in_ready, waitc);
      return;
    end
    bus.view_normal = {10'(dx), 10'(dy), 8'h5A};
    bus.point       = {10'(px), 10'(py), 8'(pz)};
    bus.view_dist   = 10'(d0);
    bus.in_valid    = 1'b1;
    e.loc   = 13'(loc);
    e.off   = off;
    e.beh   = beh;
    e.lat   = beh ? 2 : 19;
    e.stall = stall;
    e.acc   = cyc + 1;
    if (b2b) chk("accept_after_retire", 32'(e.acc), 32'(retire_cyc + 1));
    exp_q.push_back(e);
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.point       = 28'($urandom);
    bus.view_normal = 28'($urandom);
    bus.view_dist   = 10'($urandom);
  endtask

  // Monitor: pops on the first valid cycle, then checks the held result.
  initial begin
    exp_t cur;
    bit   active;
    int   stall_left;
    active        = 1'b0;
    stall_left    = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        active        = 1'b0;
        stall_left    = 0;
        bus.out_ready = 1'b1;
      end else if (bus.out_valid) begin
        if (!active) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: view_loc %0d with no request pending", bus.view_loc);
          end else begin
            cur        = exp_q.pop_front();
            active     = 1'b1;
            stall_left = cur.stall;
            chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
            chk("view_loc", 32'(bus.view_loc), 32'(cur.loc));
            chk("off_screen", 32'(bus.off_screen), 32'(cur.off));
            chk("behind", 32'(bus.behind), 32'(cur.beh));
          end
        end else begin
          chk("hold_view_loc", 32'(bus.view_loc), 32'(cur.loc));
          chk("hold_off_screen", 32'(bus.off_screen), 32'(cur.off));
          chk("hold_behind", 32'(bus.behind), 32'(cur.beh));
        end
        chk("in_ready_while_valid", 32'(bus.in_ready), 32'(0));
        if (stall_left > 0) begin
          bus.out_ready = 1'b0;
          stall_left--;
        end else begin
          bus.out_ready = 1'b1;
          active        = 1'b0;
          retire_cyc    = cyc + 1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    bus.in_valid    = 1'b0;
    bus.view_normal = '0;
    bus.view_dist   = '0;
    bus.point       = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_view_loc", 32'(bus.view_loc), 32'(0));
    chk("rst_off_screen", 32'(bus.off_screen), 32'(0));
    chk("rst_behind", 32'(bus.behind), 32'(0));
    rst = 1'b0;

    //    dx  dy   px   py  pz   d0  loc                  off beh stall b2b
    send( 1,  0,  10,   5,  4,  20, 5174,                 0,  0,  0,    0); // basic
    send( 1,  0,  -3,   0,  0,  20, 0,                    0,  1,  0,    0); // behind
    send( 1,  0,   0,   7,  0,  20, 0,                    0,  1,  0,    0); // zero depth
    send( 1,  0,   1, 100,  0, 100, CL ? 4096 : 0,        1,  0,  0,    0); // qx saturates
    send( 0,  1,   3,  32, -8,  64, 2118,                 0,  0,  5,    0); // backpressure
    send( 2, -1,  20,  -5,  3,  10, 4158,                 0,  0,  0,    1); // truncation, b2b
    send( 1,  0,  10,   0, -7, 100, CL ? 64 : 0,          1,  0,  0,    0); // y below screen
    send(-1,  0, -10,   0,  0,   5, 4160,                 0,  0,  0,    0); // centre
    send( 1,  0,   1,  -1,  0,  63, 4223,                 0,  0,  0,    0); // x = 127
    send( 1,  0,   1,  -1,  0,  64, CL ? 4223 : 0,        1,  0,  0,    0); // x = 128
    send( 1,  0,   1,  -1,  0, 128, CL ? 4223 : 0,        1,  0,  0,    0); // n == depth<<7
    send( 1,  0,   1,   0, 31,   1, 8128,                 0,  0,  0,    0); // y = 63
    send( 1,  0,   1,   0, 32,   1, CL ? 8128 : 0,        1,  0,  0,    0); // y = 64

    // Reset during DIVX: the in-flight request must vanish.
    for (int i = 0; i < 200 && (exp_q.size() != 0 || !bus.in_ready); i++) @(negedge clk);
    bus.view_normal = {10'(1), 10'(0), 8'h00};
    bus.point       = {10'(10), 10'(5), 8'(4)};
    bus.view_dist   = 10'(20);
    bus.in_valid    = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (cyc < acc + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_in_ready", 32'(bus.in_ready), 32'(1));
    chk("midreset_out_valid", 32'(bus.out_valid), 32'(0));
    chk("midreset_view_loc", 32'(bus.view_loc), 32'(0));
    rst = 1'b0;
    send( 1,  0,  10,   5,  4,  20, 5174,                 0,  0,  0,    0);

    for (int i = 0; i < 300 && (exp_q.size() != 0 || bus.out_valid); i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
